// File: rtl/alu_8bit_if.sv
// Operand/opcode/result bundle between the bench (master) and the ALU (slave).
interface alu_8bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    modport master (
        output A,
        output B,
        output ALU_Sel,
        input  ALU_Out,
        input  CarryOut
    );

    modport slave (
        input  A,
        input  B,
        input  ALU_Sel,
        output ALU_Out,
        output CarryOut
    );
endinterface

// File: rtl/alu_8bit.sv
// 16-operation ALU: operands and opcode sampled every rising edge,
// result and carry/borrow flag registered one cycle later.
module alu_8bit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_8bit_if.slave   bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;

    logic [WIDTH-1:0]   r_alu_out;
    logic               r_carry_out;

    // Wide arithmetic terms; bit WIDTH of the difference is the borrow.
    always_comb begin
        w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
        w_diff = {1'b0, bus.A} - {1'b0, bus.B};
        w_prod = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        w_quot = (bus.B == '0) ? {WIDTH{1'b1}} : (bus.A / bus.B);
    end

    // Opcode decode into the next result and flag; only ADD/SUB drive the flag.
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (bus.ALU_Sel)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
            end
            OP_MUL:  w_result = w_prod[WIDTH-1:0];
            OP_DIV:  w_result = w_quot;
            OP_SHL:  w_result = {bus.A[WIDTH-2:0], 1'b0};
            OP_SHR:  w_result = {1'b0, bus.A[WIDTH-1:1]};
            OP_ROL:  w_result = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
            OP_ROR:  w_result = {bus.A[0], bus.A[WIDTH-1:1]};
            OP_AND:  w_result = bus.A & bus.B;
            OP_OR:   w_result = bus.A | bus.B;
            OP_XOR:  w_result = bus.A ^ bus.B;
            OP_NOR:  w_result = ~(bus.A | bus.B);
            OP_NAND: w_result = ~(bus.A & bus.B);
            OP_XNOR: w_result = ~(bus.A ^ bus.B);
            OP_GT:   w_result = {{(WIDTH-1){1'b0}}, (bus.A > bus.B)};
            OP_EQ:   w_result = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
            default: begin
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
    end

    // Output register; reset clears it asynchronously and drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_out   <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_alu_out   <= w_result;
            r_carry_out <= w_carry;
        end
    end

    assign bus.ALU_Out  = r_alu_out;
    assign bus.CarryOut = r_carry_out;

endmodule

// File: tb/tb_alu_8bit.sv
// Bench for alu_8bit: directed vector table, reset and back-to-back
// sequences, then random operations against an arithmetic reference model.
module tb_alu_8bit;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] exp_out;
        logic       exp_c;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prev_out = 8'h00;
    logic       prev_c   = 1'b0;

    vec_t vecs [22];

    alu_8bit_if #(.WIDTH(8)) bus ();

    alu_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: opcode semantics in plain integer arithmetic.
    function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b,
                                    input logic [3:0] sel,
                                    output logic [7:0] out, output logic c);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        c  = 1'b0;
        case (sel)
            4'd0:  begin r = (ia + ib) % 256; c = (ia + ib) > 255; end
            4'd1:  begin r = (ia - ib + 256) % 256; c = ia < ib; end
            4'd2:  r = (ia * ib) % 256;
            4'd3:  r = (ib == 0) ? 255 : ia / ib;
            4'd4:  r = (ia * 2) % 256;
            4'd5:  r = ia / 2;
            4'd6:  r = (ia * 2) % 256 + ia / 128;
            4'd7:  r = ia / 2 + (ia % 2) * 128;
            4'd8:  r = int'(a & b);
            4'd9:  r = int'(a | b);
            4'd10: r = int'(a ^ b);
            4'd11: r = 255 - int'(a | b);
            4'd12: r = 255 - int'(a & b);
            4'd13: r = 255 - int'(a ^ b);
            4'd14: r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        out = 8'(r);
    endfunction

    task automatic check(input string name, input logic [7:0] act_out, input logic act_c,
                         input logic [7:0] exp_out, input logic exp_c);
        n_checks++;
        if (act_out === exp_out && act_c === exp_c)
            n_pass++;
        else
            $display("FAIL %s: got out=%h c=%b, want out=%h c=%b",
                     name, act_out, act_c, exp_out, exp_c);
    endtask

    // Drive on the falling edge, confirm the old result still holds, then
    // confirm the new result one rising edge later.
    task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [7:0] eo, input logic ec);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_Sel = sel;
        #1 check({name, "_hold"}, bus.ALU_Out, bus.CarryOut, prev_out, prev_c);
        @(posedge clk);
        #1 check(name, bus.ALU_Out, bus.CarryOut, eo, ec);
        prev_out = eo;
        prev_c   = ec;
    endtask

    initial begin
        logic [7:0] ra, rb, eo;
        logic [3:0] rs;
        logic       ec;

        vecs[0]  = '{"sub_0a_03",  8'h0A, 8'h03, 4'b0001, 8'h07, 1'b0};
        vecs[1]  = '{"sub_03_0a",  8'h03, 8'h0A, 4'b0001, 8'hF9, 1'b1};
        vecs[2]  = '{"sub_eq",     8'h55, 8'h55, 4'b0001, 8'h00, 1'b0};
        vecs[3]  = '{"add_wrap",   8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1};
        vecs[4]  = '{"add_plain",  8'h10, 8'h20, 4'b0000, 8'h30, 1'b0};
        vecs[5]  = '{"mul_wrap",   8'h10, 8'h10, 4'b0010, 8'h00, 1'b0};
        vecs[6]  = '{"mul_plain",  8'h0C, 8'h05, 4'b0010, 8'h3C, 1'b0};
        vecs[7]  = '{"div_plain",  8'h64, 8'h07, 4'b0011, 8'h0E, 1'b0};
        vecs[8]  = '{"div_zero",   8'h64, 8'h00, 4'b0011, 8'hFF, 1'b0};
        vecs[9]  = '{"shl",        8'h81, 8'hA5, 4'b0100, 8'h02, 1'b0};
        vecs[10] = '{"shr",        8'h81, 8'hA5, 4'b0101, 8'h40, 1'b0};
        vecs[11] = '{"rol",        8'h81, 8'h5A, 4'b0110, 8'h03, 1'b0};
        vecs[12] = '{"ror",        8'h81, 8'h5A, 4'b0111, 8'hC0, 1'b0};
        vecs[13] = '{"and",        8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b0};
        vecs[14] = '{"or",         8'hF0, 8'h3C, 4'b1001, 8'hFC, 1'b0};
        vecs[15] = '{"xor",        8'hF0, 8'h3C, 4'b1010, 8'hCC, 1'b0};
        vecs[16] = '{"nor",        8'hF0, 8'h3C, 4'b1011, 8'h03, 1'b0};
        vecs[17] = '{"nand",       8'hF0, 8'h3C, 4'b1100, 8'hCF, 1'b0};
        vecs[18] = '{"xnor",       8'hF0, 8'h3C, 4'b1101, 8'h33, 1'b0};
        vecs[19] = '{"gt_false",   8'h03, 8'h05, 4'b1110, 8'h00, 1'b0};
        vecs[20] = '{"eq_false",   8'h03, 8'h05, 4'b1111, 8'h00, 1'b0};
        vecs[21] = '{"add_carry2", 8'h80, 8'h80, 4'b0000, 8'h00, 1'b1};

        bus.A       = 8'h00;
        bus.B       = 8'h00;
        bus.ALU_Sel = 4'h0;

        // Reset held from time zero.
        #12 check("reset_init", bus.ALU_Out, bus.CarryOut, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sel,
                  vecs[i].exp_out, vecs[i].exp_c);

        // Asynchronous reset between edges with a nonzero result pending.
        apply("pre_reset", 8'hF0, 8'h20, 4'b0000, 8'h10, 1'b1);
        #2 rst = 1'b1;
        #1 check("reset_async", bus.ALU_Out, bus.CarryOut, 8'h00, 1'b0);
        @(posedge clk);
        #1 check("reset_held", bus.ALU_Out, bus.CarryOut, 8'h00, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        bus.A       = 8'h10;
        bus.B       = 8'h20;
        bus.ALU_Sel = 4'b0000;
        #1 check("release_wait", bus.ALU_Out, bus.CarryOut, 8'h00, 1'b0);
        @(posedge clk);
        #1 check("release_first", bus.ALU_Out, bus.CarryOut, 8'h30, 1'b0);
        prev_out = 8'h30;
        prev_c   = 1'b0;

        // Compare ops alternating back-to-back.
        apply("gt_5_3", 8'h05, 8'h03, 4'b1110, 8'h01, 1'b0);
        apply("eq_5_3", 8'h05, 8'h03, 4'b1111, 8'h00, 1'b0);
        apply("gt_9_9", 8'h09, 8'h09, 4'b1110, 8'h00, 1'b0);
        apply("eq_9_9", 8'h09, 8'h09, 4'b1111, 8'h01, 1'b0);

        // Random operations against the reference model.
        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 17 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            ref_alu(ra, rb, rs, eo, ec);
            apply($sformatf("rand_%0d_op%0d", k, rs), ra, rb, rs, eo, ec);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
